instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_sequencer_if.sv | 13 +
 rtl/pc_unit.sv | 32 +++
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        TYPE_R = 2'b00,
        TYPE_I = 2'b01,
        TYPE_P = 2'b10,
        TYPE_J = 2'b11
    } instr_type_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC1 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_INC    = 2'b01,
        PC_TARGET = 2'b10
    } pc_sel_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Memory request/acknowledge bus between the sequencer and instruction/data memory.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic              mem_addr_sel;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr_sel, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_rdata, mem_ack);
endinterface

// File: rtl/pc_unit.sv
// Program counter register with hold / increment / jump-target selection.
module pc_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_e           i_sel,
    input  logic [WORD_W-1:0] i_target,
    output logic [WORD_W-1:0] o_pc
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_nxt;

    // Increment wraps naturally at the word width.
    always_comb begin
        w_pc_nxt = r_pc;
        case (i_sel)
            PC_INC:    w_pc_nxt = r_pc + WORD_W'(1);
            PC_TARGET: w_pc_nxt = i_target;
            default:   w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= '0;
        else        r_pc <= w_pc_nxt;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control sequencer.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [1:0]            dec_type,
    input  logic                  dec_wb,
    input  logic                  dec_is_load,
    input  logic                  dec_is_jalr,
    input  logic                  cond_true,
    input  logic [WORD_W-1:0]     jmp_target,
    instr_sequencer_if.master     mem_bus,
    output logic [WORD_W-1:0]     ir,
    output logic [WORD_W-1:0]     pc,
    output logic                  reg_we,
    output logic [1:0]            wb_sel,
    output logic [WORD_W-1:0]     instret
);

    state_e            r_state, w_next;
    logic              r_fetch_pend;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] r_instret;

    logic    w_mem_req, w_mem_we, w_addr_sel, w_reg_we;
    wb_sel_e w_wb_sel;
    pc_sel_e w_pc_sel;
    logic    w_fetch_done, w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    // Fetch request is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        w_reg_we   = 1'b0;
        w_wb_sel   = WB_ALU;
        w_pc_sel   = PC_HOLD;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = rst_n & (run | r_fetch_pend);
                if (w_mem_req && mem_bus.mem_ack) w_next = ST_DECODE;
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                w_next   = ST_FETCH;
                w_pc_sel = PC_INC;
                case (instr_type_e'(dec_type))
                    TYPE_R, TYPE_I: begin
                        if (dec_wb) w_reg_we = 1'b1;
                    end
                    TYPE_P: begin
                        w_next   = ST_MEM;
                        w_pc_sel = PC_HOLD;
                    end
                    TYPE_J: begin
                        if (dec_is_jalr) begin
                            w_reg_we = 1'b1;
                            w_wb_sel = WB_PC1;
                            w_pc_sel = PC_TARGET;
                        end else if (cond_true) begin
                            w_pc_sel = PC_TARGET;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = ~dec_is_load;
                if (mem_bus.mem_ack) begin
                    if (dec_is_load) begin
                        w_next = ST_WB;
                    end else begin
                        w_next   = ST_FETCH;
                        w_pc_sel = PC_INC;
                    end
                end
            end
            ST_WB: begin
                w_reg_we = 1'b1;
                w_wb_sel = WB_MEM;
                w_pc_sel = PC_INC;
                w_next   = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    assign w_fetch_done = (r_state == ST_FETCH) && w_mem_req && mem_bus.mem_ack;
    assign w_retire     = (r_state != ST_FETCH) && (w_next == ST_FETCH);

    // Pending flag keeps an issued fetch alive if run drops before the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pend <= 1'b0;
            r_ir         <= '0;
            r_instret    <= '0;
        end else begin
            r_fetch_pend <= (r_state == ST_FETCH) && w_mem_req && !mem_bus.mem_ack;
            if (w_fetch_done) r_ir <= mem_bus.mem_rdata;
            if (w_retire)     r_instret <= r_instret + WORD_W'(1);
        end
    end

    pc_unit u_pc_unit (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sel    (w_pc_sel),
        .i_target (jmp_target),
        .o_pc     (pc)
    );

    assign mem_bus.mem_req      = w_mem_req;
    assign mem_bus.mem_we       = w_mem_we;
    assign mem_bus.mem_addr_sel = w_addr_sel;
    assign ir                   = r_ir;
    assign reg_we               = w_reg_we;
    assign wb_sel               = w_wb_sel;
    assign instret              = r_instret;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against an instruction-level model.
module tb_instr_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b1;
    logic [1:0]  dec_type = 2'b00;
    logic        dec_wb = 1'b0;
    logic        dec_is_load = 1'b0;
    logic        dec_is_jalr = 1'b0;
    logic        cond_true = 1'b0;
    logic [15:0] jmp_target = 16'h0;
    logic [15:0] ir, pc, instret;
    logic        reg_we;
    logic [1:0]  wb_sel;

    instr_sequencer_if mem_if();

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .dec_type    (dec_type),
        .dec_wb      (dec_wb),
        .dec_is_load (dec_is_load),
        .dec_is_jalr (dec_is_jalr),
        .cond_true   (cond_true),
        .jmp_target  (jmp_target),
        .mem_bus     (mem_if),
        .ir          (ir),
        .pc          (pc),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_instret = 16'h0;
    logic [15:0] m_ir = 16'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        else n_pass++;
    endtask

    // One whole instruction; entered and left at a falling clock edge.
    task automatic do_instr(input logic [1:0] t, input logic wb, input logic ld,
                            input logic jalr, input logic cond, input logic [15:0] target,
                            input int idle, input int fw, input int dw, input bit drop_run);
        logic [15:0] word;
        logic [15:0] exp_pc;
        logic [1:0]  exp_wsel;
        logic        exp_mwe;
        int          exp_cyc, exp_we_cnt, exp_dreq;
        int          n, dn, we_cnt, dreq;
        bit          got;

        word       = 16'($urandom);
        exp_pc     = m_pc + 16'd1;
        exp_cyc    = 2;
        exp_we_cnt = 0;
        exp_dreq   = 0;
        exp_wsel   = 2'b00;
        exp_mwe    = 1'b0;
        case (t)
            2'b00, 2'b01: exp_we_cnt = wb ? 1 : 0;
            2'b10: begin
                exp_dreq   = dw + 1;
                exp_cyc    = 2 + dw + 1 + (ld ? 1 : 0);
                exp_we_cnt = ld ? 1 : 0;
                exp_wsel   = 2'b01;
                exp_mwe    = ~ld;
            end
            default: begin
                if (jalr) begin
                    exp_pc     = target;
                    exp_we_cnt = 1;
                    exp_wsel   = 2'b10;
                end else if (cond) begin
                    exp_pc = target;
                end
            end
        endcase

        dec_type = t; dec_wb = wb; dec_is_load = ld; dec_is_jalr = jalr;
        cond_true = cond; jmp_target = target;

        for (int c = 0; c < idle; c++) begin
            run = 1'b0;
            mem_if.mem_ack = 1'($urandom);
            #1;
            chk("idle_no_req", 32'(mem_if.mem_req), 32'(0));
            chk("idle_ir_kept", 32'(ir), 32'(m_ir));
            @(negedge clk); mem_if.mem_ack = 1'b0;
        end

        run = 1'b1; n = 0; got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            if (drop_run && n > 0) run = 1'b0;
            #1;
            if (c == 0) begin
                chk("fetch_req_start", 32'(mem_if.mem_req), 32'(1));
                chk("fetch_pc", 32'(pc), 32'(m_pc));
                chk("instret", 32'(instret), 32'(m_instret));
            end
            if (n > 0) chk("fetch_req_held", 32'(mem_if.mem_req), 32'(1));
            if (mem_if.mem_req) begin
                chk("fetch_addr_sel", 32'(mem_if.mem_addr_sel), 32'(0));
                chk("fetch_we", 32'(mem_if.mem_we), 32'(0));
                if (n == fw) begin
                    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = word; got = 1'b1;
                end
                n++;
            end
            @(negedge clk); mem_if.mem_ack = 1'b0;
        end
        if (!got) chk("fetch_timeout", 32'(0), 32'(1));
        m_ir = word;

        we_cnt = 0; dreq = 0; dn = 0;
        for (int c = 0; c < exp_cyc; c++) begin
            #1;
            if (c == 0) chk("ir_loaded", 32'(ir), 32'(word));
            if (reg_we) begin
                we_cnt++;
                chk("wb_sel", 32'(wb_sel), 32'(exp_wsel));
            end
            if (mem_if.mem_req) begin
                dreq++;
                chk("data_addr_sel", 32'(mem_if.mem_addr_sel), 32'(1));
                chk("data_we", 32'(mem_if.mem_we), 32'(exp_mwe));
                if (dn == dw) begin
                    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'($urandom);
                end
                dn++;
            end
            @(negedge clk); mem_if.mem_ack = 1'b0;
        end
        chk("reg_we_cycles", 32'(we_cnt), 32'(exp_we_cnt));
        chk("data_req_cycles", 32'(dreq), 32'(exp_dreq));

        m_pc      = exp_pc;
        m_instret = m_instret + 16'd1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(mem_if.mem_req), 32'(0));
        chk({tag, "_we"}, 32'(mem_if.mem_we), 32'(0));
        chk({tag, "_addr_sel"}, 32'(mem_if.mem_addr_sel), 32'(0));
        chk({tag, "_reg_we"}, 32'(reg_we), 32'(0));
        chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(0));
        chk({tag, "_pc"}, 32'(pc), 32'(0));
        chk({tag, "_ir"}, 32'(ir), 32'(0));
        chk({tag, "_instret"}, 32'(instret), 32'(0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 16'h0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;

        do_instr(2'b00, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);   // ADD
        do_instr(2'b10, 0, 1, 0, 0, 16'h0000, 0, 0, 3, 0);   // LOAD, slow memory
        do_instr(2'b01, 1, 0, 0, 0, 16'h0000, 0, 2, 0, 1);   // run drops mid-fetch
        do_instr(2'b11, 0, 0, 0, 1, 16'h0010, 0, 0, 0, 0);   // Jcond taken to 0x0010
        do_instr(2'b11, 0, 0, 1, 0, 16'h1234, 0, 0, 0, 0);   // JALR at 0x0010
        do_instr(2'b11, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
        do_instr(2'b11, 0, 0, 0, 0, 16'hABCD, 0, 0, 0, 0);   // not taken at 0xFFFF wraps
        do_instr(2'b11, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
        do_instr(2'b11, 0, 0, 0, 1, 16'h4321, 0, 0, 0, 0);   // taken at 0xFFFF
        do_instr(2'b00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);   // CMP
        do_instr(2'b10, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0);   // STOR

        // Reset while a data request is outstanding.
        dec_type = 2'b10; dec_is_load = 1'b1; run = 1'b1;
        #1 chk("rst_pre_fetch_req", 32'(mem_if.mem_req), 32'(1));
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBEEF;
        @(negedge clk); mem_if.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst_pre_mem_req", 32'(mem_if.mem_req), 32'(1));
        chk("rst_pre_mem_addr", 32'(mem_if.mem_addr_sel), 32'(1));
        #2 rst_n = 1'b0;
        #1 chk_reset_state("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc = 16'h0; m_instret = 16'h0; m_ir = 16'h0;
        do_instr(2'b00, 1, 0, 0, 0, 16'h0000, 3, 0, 0, 0);   // idle with run=0, then refetch at 0

        for (int i = 0; i < 300; i++) begin
            do_instr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
